// File: rtl/avalon_onchip_ram_pipelined.sv
// Parametrised Avalon-MM on-chip RAM slave with pipelined reads,
// waitrequest flow control and a hardware zero-fill engine.
module avalon_onchip_ram_pipelined #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int DEPTH          = 1024,
    parameter int READ_LATENCY   = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic                    chipselect,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    output logic                    waitrequest,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    input  logic                    clear_req,
    output logic                    clear_busy
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {READY, CLEAR} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic                    clr_last;
    logic                    accept;
    logic                    wr_acc;
    logic                    rd_acc;
    logic                    in_range;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    rd_v1;
    logic [DATA_WIDTH-1:0]   rd_d1;
    logic                    rdv_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign clear_busy  = (state == CLEAR);
    assign waitrequest = clear_busy | ~clken;
    assign accept      = chipselect & (read | write) & ~waitrequest;
    assign wr_acc      = accept & write;
    assign rd_acc      = accept & read & ~write;
    assign in_range    = ({1'b0, address} < DEPTH_W);
    assign clr_last    = (clr_cnt == LAST);
    assign rd_word     = in_range ? mem[address] : '0;

    always_comb begin
        state_next = state;
        unique case (state)
            READY: if (clken & clear_req) state_next = CLEAR;
            CLEAR: if (clken & clr_last)  state_next = READY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= CLEAR_ON_RESET ? CLEAR : READY;
            clr_cnt <= '0;
        end else if (clken) begin
            state <= state_next;
            if (state == CLEAR)
                clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
            else
                clr_cnt <= '0;
        end
    end

    // Array is deliberately not reset; the clear engine zero-fills it.
    always_ff @(posedge clk) begin
        if (clken && state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_acc && in_range) begin
            for (int i = 0; i < BYTES; i++)
                if (byteenable[i])
                    mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_v1 <= 1'b0;
            rd_d1 <= '0;
        end else if (clken) begin
            rd_v1 <= rd_acc;
            if (rd_acc)
                rd_d1 <= rd_word;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  rd_v2;
            logic [DATA_WIDTH-1:0] rd_d2;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rd_v2 <= 1'b0;
                    rd_d2 <= '0;
                end else if (clken) begin
                    rd_v2 <= rd_v1;
                    if (rd_v1)
                        rd_d2 <= rd_d1;
                end
            end

            assign rdv_q    = rd_v2;
            assign readdata = rd_d2;
        end else begin : g_lat1
            assign rdv_q    = rd_v1;
            assign readdata = rd_d1;
        end
    endgenerate

    // A pending valid is held in the pipeline while clken is low.
    assign readdatavalid = rdv_q & clken;

endmodule

// File: tb/tb_avalon_onchip_ram_pipelined.sv
// Directed bench: instance 0 is DEPTH=1000/latency 1,
// instance 1 is DEPTH=1024/latency 2.
module tb_avalon_onchip_ram_pipelined;

    logic        clk;
    logic        reset_n;
    logic        clken;
    logic [1:0]  cs;
    logic [9:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [1:0]  clr;
    logic [1:0]  waitreq;
    logic [1:0]  rdv;
    logic [1:0]  busy;
    logic [31:0] rdata [2];

    int n_cmp = 0;
    int n_bad = 0;

    avalon_onchip_ram_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1000),
        .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)
    ) u_l1 (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .chipselect(cs[0]), .address(address),
        .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitreq[0]),
        .readdata(rdata[0]), .readdatavalid(rdv[0]),
        .clear_req(clr[0]), .clear_busy(busy[0])
    );

    avalon_onchip_ram_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1024),
        .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
    ) u_l2 (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .chipselect(cs[1]), .address(address),
        .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitreq[1]),
        .readdata(rdata[1]), .readdatavalid(rdv[1]),
        .clear_req(clr[1]), .clear_busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int sel, input logic [9:0] a,
                      input logic [31:0] d, input logic [3:0] be);
        address    = a;
        writedata  = d;
        byteenable = be;
        write      = 1'b1;
        cs[sel]    = 1'b1;
        step;
        write = 1'b0;
        cs    = '0;
    endtask

    task automatic rd_chk(input int sel, input logic [9:0] a,
                          input logic [31:0] exp, input string tag);
        int lat;
        lat     = (sel == 0) ? 1 : 2;
        address = a;
        read    = 1'b1;
        cs[sel] = 1'b1;
        step;
        read = 1'b0;
        cs   = '0;
        for (int i = 1; i <= lat; i++) begin
            chk({tag, "_valid"}, 32'(rdv[sel]), 32'(i == lat));
            if (i < lat) step;
        end
        chk({tag, "_data"}, rdata[sel], exp);
        step;
        chk({tag, "_pulse_end"}, 32'(rdv[sel]), 32'd0);
    endtask

    initial begin
        int n;
        int n1;
        int n2;
        reset_n    = 1'b0;
        clken      = 1'b1;
        cs         = '0;
        address    = '0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        byteenable = '0;
        clr        = '0;
        step;
        step;
        chk("rst_rdv", 32'(rdv), 32'd0);
        chk("rst_rdata0", rdata[0], 32'd0);
        chk("rst_rdata1", rdata[1], 32'd0);
        chk("rst_busy", 32'(busy), 32'd3);
        chk("rst_wait", 32'(waitreq), 32'd3);

        // Auto clear after reset release.
        reset_n = 1'b1;
        n  = 0;
        n1 = 0;
        n2 = 0;
        while ((busy != 2'b00) && n < 2000) begin
            step;
            n++;
            if (!busy[0] && n1 == 0) n1 = n;
            if (!busy[1] && n2 == 0) n2 = n;
        end
        chk("clr_cycles_1000", n1, 32'd1000);
        chk("clr_cycles_1024", n2, 32'd1024);
        chk("clr_wait_done", 32'(waitreq), 32'd0);
        rd_chk(1, 10'd0,    32'd0, "clr_a0");
        rd_chk(1, 10'd511,  32'd0, "clr_a511");
        rd_chk(1, 10'd1023, 32'd0, "clr_a1023");
        rd_chk(0, 10'd999,  32'd0, "clr_l1_a999");

        // Byte-lane writes, both latencies.
        for (int s = 0; s < 2; s++) begin
            wr(s, 10'd5, 32'hDEADBEEF, 4'b1111);
            wr(s, 10'd5, 32'h00000011, 4'b0001);
            rd_chk(s, 10'd5, 32'hDEADBE11, "be_merge");
        end
        wr(0, 10'd5, 32'hFFFFFFFF, 4'b0000);
        rd_chk(0, 10'd5, 32'hDEADBE11, "be_none");

        // Read+write together acts as write only.
        address    = 10'd6;
        writedata  = 32'h0BADF00D;
        byteenable = 4'hF;
        read       = 1'b1;
        write      = 1'b1;
        cs[0]      = 1'b1;
        step;
        read  = 1'b0;
        write = 1'b0;
        cs    = '0;
        chk("rw_no_valid", 32'(rdv[0]), 32'd0);
        rd_chk(0, 10'd6, 32'h0BADF00D, "rw_data");

        // Back-to-back reads, latency 2.
        wr(1, 10'd1, 32'h11111111, 4'hF);
        wr(1, 10'd2, 32'h22222222, 4'hF);
        wr(1, 10'd3, 32'h33333333, 4'hF);
        read  = 1'b1;
        cs[1] = 1'b1;
        address = 10'd1;
        step;
        chk("b2b_v0", 32'(rdv[1]), 32'd0);
        address = 10'd2;
        step;
        chk("b2b_v1", 32'(rdv[1]), 32'd1);
        chk("b2b_d1", rdata[1], 32'h11111111);
        address = 10'd3;
        step;
        read = 1'b0;
        cs   = '0;
        chk("b2b_v2", 32'(rdv[1]), 32'd1);
        chk("b2b_d2", rdata[1], 32'h22222222);
        step;
        chk("b2b_v3", 32'(rdv[1]), 32'd1);
        chk("b2b_d3", rdata[1], 32'h33333333);
        step;
        chk("b2b_end", 32'(rdv[1]), 32'd0);

        // Clear request alongside an accepted read.
        address = 10'd5;
        read    = 1'b1;
        cs[1]   = 1'b1;
        clr[1]  = 1'b1;
        step;
        read = 1'b0;
        cs   = '0;
        clr  = '0;
        chk("cq_busy", 32'(busy[1]), 32'd1);
        chk("cq_wait", 32'(waitreq[1]), 32'd1);
        step;
        chk("cq_valid", 32'(rdv[1]), 32'd1);
        chk("cq_data", rdata[1], 32'hDEADBE11);
        n = 2;
        while (busy[1] && n < 2000) begin
            step;
            n++;
        end
        chk("cq_cycles", n, 32'd1025);
        rd_chk(1, 10'd5, 32'd0, "cq_cleared");

        // clken stall with a read in flight, latency 1.
        wr(0, 10'd7, 32'hCAFEF00D, 4'hF);
        address = 10'd7;
        read    = 1'b1;
        cs[0]   = 1'b1;
        step;
        read  = 1'b0;
        cs    = '0;
        clken = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("ck_hold_valid", 32'(rdv[0]), 32'd0);
            chk("ck_wait", 32'(waitreq[0]), 32'd1);
            if (i < 2) step;
        end
        step;
        clken = 1'b1;
        #1;
        chk("ck_valid", 32'(rdv[0]), 32'd1);
        chk("ck_data", rdata[0], 32'hCAFEF00D);
        step;
        chk("ck_end", 32'(rdv[0]), 32'd0);

        // Out-of-range on DEPTH=1000.
        wr(0, 10'd10, 32'hA5A5A5A5, 4'hF);
        wr(0, 10'd1010, 32'h12345678, 4'hF);
        rd_chk(0, 10'd1010, 32'd0, "oor_read");
        rd_chk(0, 10'd10, 32'hA5A5A5A5, "oor_alias");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/avalon_onchip_ram_pipelined.md
Name: avalon_onchip_ram_pipelined

Overview:
Parametrised Avalon-MM on-chip RAM slave. It is the successor to the fixed 1024x32 single-port memory used by the processor system.
- Adds configurable width, depth and read latency, plus an explicit readdatavalid pipeline and waitrequest flow control.
- Adds a hardware clear engine that zero-fills the array after reset or on command.
- Sits on the system interconnect as a data/instruction memory slave.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 10, word address width.
DEPTH, 1024, number of words; DEPTH <= 2**ADDR_WIDTH.
READ_LATENCY, 1, cycles from read acceptance to readdatavalid; legal values 1 or 2.
CLEAR_ON_RESET, 1, 1 = zero-fill the array automatically after reset release.

Ports:
clk  in  1  system clock; all logic on the rising edge.
reset_n  in  1  asynchronous active-low reset.
clken  in  1  global clock enable; 0 freezes all state.
chipselect  in  1  slave select.
address  in  ADDR_WIDTH  word address.
read  in  1  read request.
write  in  1  write request.
writedata  in  DATA_WIDTH  write data.
byteenable  in  DATA_WIDTH/8  byte lanes for writes.
waitrequest  out  1  1 = request not accepted this cycle.
readdata  out  DATA_WIDTH  read data.
readdatavalid  out  1  one-cycle pulse qualifying readdata.
clear_req  in  1  level/pulse request to zero-fill the array.
clear_busy  out  1  1 while the clear engine is running.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - readdata=0, readdatavalid=0, read pipeline flushed, clear counter=0.
  - State is CLEAR if CLEAR_ON_RESET=1, else READY.
  - Array contents are not reset.
- waitrequest is combinational: waitrequest = (state==CLEAR) | ~clken.
- Acceptance: an access is accepted when chipselect & (read|write) & ~waitrequest.
- FSM states:
  - READY: accepts accesses. clear_req=1 -> CLEAR on the next edge. Any access accepted in the same cycle completes normally.
  - CLEAR: one word per clken cycle, addresses 0..DEPTH-1 ascending, written with all-zero data and all bytes enabled. After address DEPTH-1 is written -> READY on the next edge.
    - clear_busy=1 throughout CLEAR.
    - clear_req is ignored while in CLEAR.
    - A clear takes exactly DEPTH cycles with clken=1.
- Writes: only lanes with byteenable[i]=1 are updated. byteenable=0 is accepted with no change. No readdatavalid is produced for a write.
- Reads:
  - Full word returned; byteenable is ignored.
  - readdatavalid pulses exactly READ_LATENCY clken cycles after acceptance.
  - Fully pipelined: one read may be accepted every cycle, and valids return in order.
  - READ_LATENCY=2 adds an output register stage.
- Write at cycle N followed by a read of the same address at N+1 returns the new data.
- read & write both asserted: treated as a write only; no readdatavalid.
- Out of range (address >= DEPTH): writes are accepted and discarded; reads are accepted and return 0 with a normal readdatavalid.
- clken=0: no acceptance, read pipeline and clear counter frozen, readdatavalid held at 0. Outputs resume where they left off when clken returns.
- Reads in flight when a clear starts still complete with their pre-clear data.
- Reset asserted mid-clear restarts the clear from address 0 (if CLEAR_ON_RESET=1).
- readdata holds its last valid value when readdatavalid=0.

Test Plan:
1. CLEAR_ON_RESET=1, DEPTH=1024, release reset_n -> clear_busy=1 and waitrequest=1 for exactly 1024 cycles; then reads of addresses 0, 511 and 1023 return 0.
2. Write 0xDEADBEEF to addr 5 with byteenable=4'b1111, then write 0x00000011 with byteenable=4'b0001; read addr 5 -> readdata=0xDEADBE11, readdatavalid exactly READ_LATENCY cycles after acceptance (run for both 1 and 2).
3. Back-to-back reads of addrs 1, 2, 3 on consecutive cycles with READ_LATENCY=2 -> three consecutive readdatavalid pulses with the data in order.
4. Pulse clear_req in the same cycle as an accepted read of addr 5 holding 0xDEADBE11 -> the read returns 0xDEADBE11, then clear runs for DEPTH cycles, then addr 5 reads 0.
5. Deassert clken for 3 cycles with a read in flight -> readdatavalid is delayed by exactly 3 cycles and waitrequest=1 while clken=0.
6. DEPTH=1000, ADDR_WIDTH=10: write 0x12345678 to addr 1010, then read addr 1010 -> readdata=0 with readdatavalid=1; addr 1010 mod 1000 (addr 10) is unchanged.
